dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving load/store requests from the M stage; the memory-side end of the ld_data path that the MEM/WB register captures.
- Word-organised RAM with byte-lane write strobes and a configurable number of wait states.
- Drives a stall back to the pipeline until each access completes.

Parameters:
ADDR_BITS, 10, word-address width; depth = 2^ADDR_BITS 32-bit words
WAIT_CYCLES, 2, extra wait states per access (0..15)

Ports:
clk  input  1  pipeline clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  M stage has a memory access; held stable while stall=1
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address; word index = req_addr[ADDR_BITS+1:2]
req_be  input  4  store byte strobes; bit i writes byte lane i (ignored for loads)
req_wdata  input  32  store data, lane-aligned
stall  output  1  pipeline hold request
ld_data  output  32  registered load word (raw, no extension)
resp_valid  output  1  access completed this cycle

Behaviour:
- Reset: state=IDLE, cnt=0, ld_data=0, resp_valid=0, stall=0 whenever req_valid=0. RAM contents are not reset.
- States: IDLE, BUSY, DONE. cnt is a 4-bit down-counter.
- IDLE, req_valid=1: if WAIT_CYCLES=0 go to DONE, otherwise go to BUSY with cnt=WAIT_CYCLES-1.
- IDLE, req_valid=0: stay in IDLE.
- BUSY, req_valid=1: if cnt=0 go to DONE, otherwise decrement cnt.
- BUSY, req_valid=0 (flush): return to IDLE. No write, ld_data unchanged, no resp_valid.
- DONE: always returns to IDLE on the next edge.
- Access executes on the edge that enters DONE:
  - Load: ld_data <= RAM[word].
  - Store: RAM[word] lane i <= req_wdata lane i for each set req_be[i]; ld_data holds its previous value.
- stall (combinational) = req_valid AND state!=DONE.
  - Each access therefore stalls WAIT_CYCLES+1 cycles.
  - stall drops in the DONE cycle, letting the M stage advance.
- resp_valid = registered 1 exactly in the DONE cycle; 0 otherwise.
- ld_data keeps its value until the next completed load, so the MEM/WB register can sample it in the DONE cycle.
- Back-to-back: a new request present in the cycle after DONE starts from IDLE. Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles.
- Address handling:
  - req_addr[1:0] is ignored.
  - Address bits above ADDR_BITS+1 are ignored, so addresses wrap modulo depth.
- Store with req_be=0: runs the full timing and resp_valid, but leaves RAM unchanged.
- Reset asserted mid-access: returns to IDLE immediately. The pending store is not performed and ld_data clears to 0.
- Read-after-write to the same word in consecutive requests returns the newly written data.

Test Plan:
- Reset, then load 0x0 with WAIT_CYCLES=2, req_valid held -> stall=1 for 3 cycles, 4th cycle stall=0, resp_valid=1, ld_data=RAM[0].
- Store 0xDEADBEEF to 0x10 with be=4'b1111, then load 0x10 -> resp_valid per access, ld_data=0xDEADBEEF.
- Store 0x000000AA to 0x10 with be=4'b0001 over 0xDEADBEEF, then load 0x10 -> ld_data=0xDEADBEAA.
- Drop req_valid in the first BUSY cycle of a store of 0x12345678 to 0x20 -> next cycle state IDLE, no resp_valid, later load 0x20 returns the old value.
- Assert rst during BUSY of a store -> stall=0 (req_valid low), ld_data=0, RAM word unchanged, a fresh load after reset completes in 3 stall cycles.
- WAIT_CYCLES=0 build: load -> 1 stall cycle then DONE. Address 0x1000 with ADDR_BITS=10 aliases address 0x0.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-organised data memory for the M stage with byte-lane store strobes and a fixed
// number of wait states; stalls the pipeline until each access reaches its DONE cycle.
`timescale 1ns/1ps
module dmem_responder #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] ld_data,
   output logic        resp_valid
);

   localparam int         DEPTH    = 1 << ADDR_BITS;
   localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_r;
   logic [3:0]             cnt_r;
   logic [31:0]            mem_r [DEPTH];
   logic [ADDR_BITS-1:0]   word_s;
   logic                   fire_s;
   logic                   addr_unused_s;

   // Lane merge: each set strobe replaces its byte, cleared strobes keep the old byte.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

   assign word_s        = req_addr[ADDR_BITS+1:2];
   assign addr_unused_s = ^{req_addr[31:ADDR_BITS+2], req_addr[1:0]};
   assign stall         = req_valid && (state_r != DONE);

   // Detect the edge that enters DONE; the access itself happens on that edge.
   always_comb begin
      fire_s = 1'b0;
      case (state_r)
         IDLE:    fire_s = req_valid && NO_WAIT;
         BUSY:    fire_s = req_valid && (cnt_r == 4'd0);
         default: fire_s = 1'b0;
      endcase
   end

   // RAM array: not reset, writes only on a completing store outside reset.
   always_ff @(posedge clk) begin
      if (fire_s && req_we && !rst) begin
         mem_r[word_s] <= merge_lanes(mem_r[word_s], req_wdata, req_be);
      end
   end

   // Access FSM, wait-state counter and registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= 4'd0;
         ld_data    <= 32'd0;
         resp_valid <= 1'b0;
      end else begin
         resp_valid <= fire_s;
         if (fire_s && !req_we) begin
            ld_data <= mem_r[word_s];
         end
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  if (NO_WAIT) begin
                     state_r <= DONE;
                  end else begin
                     state_r <= BUSY;
                     cnt_r   <= CNT_INIT;
                  end
               end
            end
            BUSY: begin
               // A dropped request is a flush: abandon the access without side effects.
               if (!req_valid) begin
                  state_r <= IDLE;
               end else if (cnt_r == 4'd0) begin
                  state_r <= DONE;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            DONE:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
`timescale 1ns/1ps
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        stall, resp_valid;
   logic [31:0] ld_data;
   logic        z_valid, z_we;
   logic [31:0] z_addr, z_wdata;
   logic [3:0]  z_be;
   logic        z_stall, z_resp_valid;
   logic [31:0] z_ld_data;

   int n_tests = 0;
   int n_fail  = 0;

   int          stalls;
   logic        resp, early;
   logic [31:0] ld;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_be(req_be), .req_wdata(req_wdata), .stall(stall), .ld_data(ld_data),
      .resp_valid(resp_valid)
   );

   dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(z_valid), .req_we(z_we), .req_addr(z_addr),
      .req_be(z_be), .req_wdata(z_wdata), .stall(z_stall), .ld_data(z_ld_data),
      .resp_valid(z_resp_valid)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One access from IDLE, entered at posedge+1; returns stall count, DONE-cycle outputs.
   task automatic access(input bit sel0, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         output int n_stall, output logic r, output logic [31:0] d,
                         output logic early_r);
      if (sel0) begin
         z_valid = 1'b1; z_we = we; z_addr = addr; z_be = be; z_wdata = wd;
      end else begin
         req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
      end
      n_stall = 0;
      early_r = 1'b0;
      #1;
      while ((sel0 ? z_stall : stall) && n_stall < 20) begin
         n_stall++;
         if (sel0 ? z_resp_valid : resp_valid) early_r = 1'b1;
         @(posedge clk); #1;
      end
      r = sel0 ? z_resp_valid : resp_valid;
      d = sel0 ? z_ld_data : ld_data;
      z_valid = 1'b0; req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_be = 4'd0; req_wdata = 32'd0;
      z_valid = 1'b0; z_we = 1'b0; z_addr = 32'd0; z_be = 4'd0; z_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_resp", {31'd0, resp_valid}, 32'd0);
      check("rst_ld", ld_data, 32'd0);
      check("rst_ld0", z_ld_data, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Seed word 0, then the basic load timing: 3 stall cycles, response in the 4th.
      access(1'b0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, stalls, resp, ld, early);
      check("st0_stalls", stalls, 32'd3);
      check("st0_resp", {31'd0, resp}, 32'd1);
      access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, stalls, resp, ld, early);
      check("ld0_stalls", stalls, 32'd3);
      check("ld0_resp", {31'd0, resp}, 32'd1);
      check("ld0_early", {31'd0, early}, 32'd0);
      check("ld0_data", ld, 32'hCAFEF00D);

      // Full-word store, ld_data holds across the store, then read-after-write.
      access(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, stalls, resp, ld, early);
      check("st10_resp", {31'd0, resp}, 32'd1);
      check("st10_ldhold", ld, 32'hCAFEF00D);
      access(1'b0, 1'b0, 32'h10, 4'h0, 32'h0, stalls, resp, ld, early);
      check("ld10_data", ld, 32'hDEADBEEF);

      // Single-lane store merges into the existing word.
      access(1'b0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, stalls, resp, ld, early);
      access(1'b0, 1'b0, 32'h10, 4'h0, 32'h0, stalls, resp, ld, early);
      check("ld10_lane0", ld, 32'hDEADBEAA);

      // be=0 store: full timing and response, no RAM change.
      access(1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, stalls, resp, ld, early);
      check("be0_stalls", stalls, 32'd3);
      check("be0_resp", {31'd0, resp}, 32'd1);
      access(1'b0, 1'b0, 32'h10, 4'h0, 32'h0, stalls, resp, ld, early);
      check("be0_data", ld, 32'hDEADBEAA);

      // Upper address bits and byte offset are ignored: 0x1012 aliases word 0x10.
      access(1'b0, 1'b0, 32'h1012, 4'h0, 32'h0, stalls, resp, ld, early);
      check("alias_data", ld, 32'hDEADBEAA);

      // Flush: drop req_valid in the first BUSY cycle of a store.
      access(1'b0, 1'b1, 32'h20, 4'hF, 32'h11112222, stalls, resp, ld, early);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("flush_resp", {31'd0, resp_valid}, 32'd0);
      end
      check("flush_ldhold", ld_data, 32'hDEADBEAA);
      access(1'b0, 1'b0, 32'h20, 4'h0, 32'h0, stalls, resp, ld, early);
      check("flush_stalls", stalls, 32'd3);
      check("flush_data", ld, 32'h11112222);

      // Reset during BUSY of a store: abandoned store, ld_data cleared.
      access(1'b0, 1'b1, 32'h30, 4'hF, 32'h0BADF00D, stalls, resp, ld, early);
      access(1'b0, 1'b0, 32'h30, 4'h0, 32'h0, stalls, resp, ld, early);
      check("pre_rst_data", ld, 32'h0BADF00D);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_be = 4'hF; req_wdata = 32'h55555555;
      @(posedge clk); #1;
      rst = 1'b1; req_valid = 1'b0;
      #1;
      check("mid_rst_ld", ld_data, 32'd0);
      check("mid_rst_stall", {31'd0, stall}, 32'd0);
      check("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      access(1'b0, 1'b0, 32'h30, 4'h0, 32'h0, stalls, resp, ld, early);
      check("post_rst_stalls", stalls, 32'd3);
      check("post_rst_resp", {31'd0, resp}, 32'd1);
      check("post_rst_data", ld, 32'h0BADF00D);

      // Zero-wait instance: one stall cycle per access; 0x1000 aliases 0x0.
      access(1'b1, 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, stalls, resp, ld, early);
      check("w0_st_stalls", stalls, 32'd1);
      check("w0_st_resp", {31'd0, resp}, 32'd1);
      access(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, stalls, resp, ld, early);
      check("w0_ld_stalls", stalls, 32'd1);
      check("w0_ld_data", ld, 32'hA5A5A5A5);
      check("w0_idle_resp", {31'd0, z_resp_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
